// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse cursor renderer: packet bit layout,
// default screen geometry, cursor colours and update FSM encoding.
package mouse_pkg;

    // Default visible screen geometry
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    // PS/2 mouse status byte bit positions
    localparam int BIT_LEFT   = 0;
    localparam int BIT_RIGHT  = 1;
    localparam int BIT_MIDDLE = 2;
    localparam int BIT_XSIGN  = 4;
    localparam int BIT_YSIGN  = 5;
    localparam int BIT_XOVF   = 6;
    localparam int BIT_YOVF   = 7;

    // Cursor colours, {R,G,B} nibbles
    localparam logic [11:0] COLOR_LEFT   = 12'hF00;
    localparam logic [11:0] COLOR_RIGHT  = 12'h00F;
    localparam logic [11:0] COLOR_MIDDLE = 12'h0F0;
    localparam logic [11:0] COLOR_IDLE   = 12'hFFF;

    // Position update FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD_X = 2'd1,
        ST_ADD_Y = 2'd2
    } state_t;

    // Cursor colour from the latched buttons; left beats right beats middle
    function automatic logic [11:0] cursor_color(input logic [2:0] btn);
        if (btn[BIT_LEFT])
            return COLOR_LEFT;
        else if (btn[BIT_RIGHT])
            return COLOR_RIGHT;
        else if (btn[BIT_MIDDLE])
            return COLOR_MIDDLE;
        else
            return COLOR_IDLE;
    endfunction

endpackage

// File: rtl/delta_clamp.sv
// One axis of cursor movement: adds (or subtracts) a 9-bit two's complement
// delta to a 10-bit position in 11-bit signed arithmetic and clamps the
// result into [0, LIMIT]. Purely combinational.
module delta_clamp #(
    parameter int LIMIT = 639
) (
    input  logic [9:0] pos,
    input  logic [8:0] delta,
    input  logic       subtract,
    output logic [9:0] result
);

    localparam logic signed [10:0] LIM = 11'(LIMIT);

    logic signed [10:0] pos_s;
    logic signed [10:0] delta_s;
    logic signed [10:0] sum;

    // Widen both operands, combine, then saturate instead of wrapping
    always_comb begin
        pos_s   = signed'({1'b0, pos});
        delta_s = signed'({{2{delta[8]}}, delta});
        if (subtract)
            sum = pos_s - delta_s;
        else
            sum = pos_s + delta_s;

        if (sum[10])
            result = '0;
        else if (sum > LIM)
            result = LIM[9:0];
        else
            result = sum[9:0];
    end

endmodule

// File: rtl/mouse_cursor_render.sv
// Mouse cursor renderer: accepts PS/2 mouse packets, moves a clamped cursor
// one axis per cycle, latches the cursor once per frame during vblank and
// overlays a coloured square on the VGA pixel stream.
//
// Handshake: PacketValid is a one-cycle strobe with no ready. A strobe seen
// while the FSM is IDLE is accepted; a strobe seen while Busy is dropped and
// counted in DropCount (saturating), leaving the update in flight untouched.
module mouse_cursor_render
    import mouse_pkg::*;
#(
    parameter int          H_RES       = H_RES_DEF,
    parameter int          V_RES       = V_RES_DEF,
    parameter int          CURSOR_SIZE = 8,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PacketValid,
    input  logic [31:0] MouseState,
    input  logic        PixelTick,
    input  logic        VideoOn,
    input  logic [9:0]  PixelX,
    input  logic [9:0]  PixelY,
    output logic [11:0] RGB,
    output logic [9:0]  CursorX,
    output logic [9:0]  CursorY,
    output logic        Busy,
    output logic [7:0]  DropCount,
    output state_t      DbgState
);

    localparam logic [9:0] X_HOME = 10'(H_RES / 2);
    localparam logic [9:0] Y_HOME = 10'(V_RES / 2);
    localparam logic [9:0] VBLANK_LINE = 10'(V_RES);
    localparam logic [9:0] CSIZE = 10'(CURSOR_SIZE);

    state_t      state;
    logic [8:0]  dx;
    logic [8:0]  dy;
    logic        x_ovf;
    logic        y_ovf;
    logic [2:0]  btn;

    logic [9:0]  next_x;
    logic [9:0]  next_y;

    logic [9:0]  disp_x;
    logic [9:0]  disp_y;
    logic [2:0]  disp_btn;

    logic [9:0]  rel_x;
    logic [9:0]  rel_y;
    logic        hit;
    logic        vblank_latch;

    // Status bit 3 and the top byte carry nothing this block uses
    logic        unused_bits;
    assign unused_bits = ^{MouseState[31:24], MouseState[3]};

    assign DbgState = state;

    // Horizontal motion adds the delta
    delta_clamp #(.LIMIT(H_RES - 1)) u_clamp_x (
        .pos      (CursorX),
        .delta    (dx),
        .subtract (1'b0),
        .result   (next_x)
    );

    // Positive PS/2 Y moves up the screen, so it is subtracted
    delta_clamp #(.LIMIT(V_RES - 1)) u_clamp_y (
        .pos      (CursorY),
        .delta    (dy),
        .subtract (1'b1),
        .result   (next_y)
    );

    // Packet capture, one-axis-per-cycle update, and drop counting
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            Busy      <= 1'b0;
            CursorX   <= X_HOME;
            CursorY   <= Y_HOME;
            dx        <= '0;
            dy        <= '0;
            x_ovf     <= 1'b0;
            y_ovf     <= 1'b0;
            btn       <= '0;
            DropCount <= '0;
        end else begin
            if (PacketValid && (state != ST_IDLE) && (DropCount != 8'hFF))
                DropCount <= DropCount + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (PacketValid) begin
                        dx    <= {MouseState[BIT_XSIGN], MouseState[15:8]};
                        dy    <= {MouseState[BIT_YSIGN], MouseState[23:16]};
                        x_ovf <= MouseState[BIT_XOVF];
                        y_ovf <= MouseState[BIT_YOVF];
                        btn   <= {MouseState[BIT_MIDDLE], MouseState[BIT_RIGHT],
                                  MouseState[BIT_LEFT]};
                        state <= ST_ADD_X;
                        Busy  <= 1'b1;
                    end
                end
                ST_ADD_X: begin
                    if (!x_ovf)
                        CursorX <= next_x;
                    state <= ST_ADD_Y;
                end
                ST_ADD_Y: begin
                    if (!y_ovf)
                        CursorY <= next_y;
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    assign vblank_latch = PixelTick && (PixelX == 10'd0) && (PixelY == VBLANK_LINE);

    // Snapshot cursor once per frame so the drawn square never tears
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            disp_x   <= X_HOME;
            disp_y   <= Y_HOME;
            disp_btn <= '0;
        end else if (vblank_latch) begin
            disp_x   <= CursorX;
            disp_y   <= CursorY;
            disp_btn <= btn;
        end
    end

    // Unsigned offsets wrap to large values left/above the cursor
    assign rel_x = PixelX - disp_x;
    assign rel_y = PixelY - disp_y;
    assign hit   = (rel_x < CSIZE) && (rel_y < CSIZE);

    // Pixel colour register, advancing only at pixel rate
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RGB <= '0;
        end else if (PixelTick) begin
            if (!VideoOn)
                RGB <= '0;
            else if (hit)
                RGB <= cursor_color(disp_btn);
            else
                RGB <= BG_COLOR;
        end
    end

endmodule

// File: tb/tb_mouse_cursor_render.sv
// Directed bench for mouse_cursor_render: packet updates, clamping,
// overflow handling, drop counting, vblank latching and pixel colouring.
module tb_mouse_cursor_render;
    import mouse_pkg::*;

    localparam logic [11:0] BG = 12'h123;

    logic        Clk;
    logic        Reset;
    logic        PacketValid;
    logic [31:0] MouseState;
    logic        PixelTick;
    logic        VideoOn;
    logic [9:0]  PixelX;
    logic [9:0]  PixelY;
    logic [11:0] RGB;
    logic [9:0]  CursorX;
    logic [9:0]  CursorY;
    logic        Busy;
    logic [7:0]  DropCount;
    state_t      DbgState;

    int checks = 0;
    int errors = 0;

    mouse_cursor_render #(
        .H_RES       (640),
        .V_RES       (480),
        .CURSOR_SIZE (8),
        .BG_COLOR    (BG)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PacketValid (PacketValid),
        .MouseState  (MouseState),
        .PixelTick   (PixelTick),
        .VideoOn     (VideoOn),
        .PixelX      (PixelX),
        .PixelY      (PixelY),
        .RGB         (RGB),
        .CursorX     (CursorX),
        .CursorY     (CursorY),
        .Busy        (Busy),
        .DropCount   (DropCount),
        .DbgState    (DbgState)
    );

    // Clock: 50 MHz
    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pkt(input logic [7:0] st, input logic [7:0] x,
                                        input logic [7:0] y);
        return {8'hA5, y, x, st};
    endfunction

    task automatic tick();
        @(negedge Clk);
    endtask

    // Returns in cycle N+1 (FSM in ADD_X)
    task automatic start_packet(input logic [31:0] ms);
        PacketValid = 1'b1;
        MouseState  = ms;
        tick();
        PacketValid = 1'b0;
    endtask

    // Returns in cycle N+3, both axes written
    task automatic send_packet(input logic [31:0] ms);
        start_packet(ms);
        tick();
        tick();
    endtask

    task automatic vblank();
        PixelTick = 1'b1;
        PixelX    = 10'd0;
        PixelY    = 10'd480;
        VideoOn   = 1'b0;
        tick();
        PixelTick = 1'b0;
    endtask

    task automatic pixel(input int x, input int y, input logic von);
        PixelTick = 1'b1;
        PixelX    = 10'(x);
        PixelY    = 10'(y);
        VideoOn   = von;
        tick();
        PixelTick = 1'b0;
    endtask

    initial begin
        Reset       = 1'b1;
        PacketValid = 1'b0;
        MouseState  = '0;
        PixelTick   = 1'b0;
        VideoOn     = 1'b0;
        PixelX      = '0;
        PixelY      = '0;
        repeat (2) tick();

        // Reset state
        chk("rst_x", 32'(CursorX), 32'd320);
        chk("rst_y", 32'(CursorY), 32'd240);
        chk("rst_rgb", 32'(RGB), 32'h0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_drop", 32'(DropCount), 32'd0);
        chk("rst_state", 32'(DbgState), 32'(ST_IDLE));
        Reset = 1'b0;
        tick();

        // Basic +10 X move with latency and Busy window
        start_packet(pkt(8'h08, 8'h0A, 8'h00));
        chk("n1_busy", 32'(Busy), 32'd1);
        chk("n1_state", 32'(DbgState), 32'(ST_ADD_X));
        chk("n1_x_old", 32'(CursorX), 32'd320);
        tick();
        chk("n2_x", 32'(CursorX), 32'd330);
        chk("n2_busy", 32'(Busy), 32'd1);
        chk("n2_state", 32'(DbgState), 32'(ST_ADD_Y));
        tick();
        chk("n3_busy", 32'(Busy), 32'd0);
        chk("n3_y", 32'(CursorY), 32'd240);

        // X overflow: X frozen, Y still moves up by 3
        send_packet(pkt(8'h48, 8'h50, 8'h03));
        chk("ovf_x", 32'(CursorX), 32'd330);
        chk("ovf_y", 32'(CursorY), 32'd237);

        // Packet Y=-3, second strobe at N+1 is dropped
        PacketValid = 1'b1;
        MouseState  = pkt(8'h28, 8'h00, 8'hFD);
        tick();
        MouseState  = pkt(8'h08, 8'h7F, 8'h00);
        tick();
        PacketValid = 1'b0;
        chk("drop_cnt1", 32'(DropCount), 32'd1);
        tick();
        chk("drop_y", 32'(CursorY), 32'd240);
        tick();
        chk("drop_busy", 32'(Busy), 32'd0);
        chk("drop_x", 32'(CursorX), 32'd330);

        // Latch (330,240) with no buttons
        vblank();
        chk("vb_rgb", 32'(RGB), 32'h0);
        pixel(332, 242, 1'b1);
        chk("pix_white", 32'(RGB), 32'hFFF);
        PixelX = 10'd500;
        tick();
        chk("rgb_hold", 32'(RGB), 32'hFFF);

        // Left pressed: old latch still drawn until next vblank
        send_packet(pkt(8'h09, 8'h00, 8'h00));
        pixel(332, 242, 1'b1);
        chk("pix_prelatch", 32'(RGB), 32'hFFF);
        vblank();
        pixel(332, 242, 1'b1);
        chk("pix_left", 32'(RGB), 32'hF00);
        pixel(339, 240, 1'b1);
        chk("pix_bg_339", 32'(RGB), 32'(BG));
        pixel(337, 247, 1'b1);
        chk("pix_corner", 32'(RGB), 32'hF00);
        pixel(338, 247, 1'b1);
        chk("pix_right_edge", 32'(RGB), 32'(BG));
        pixel(337, 248, 1'b1);
        chk("pix_bottom_edge", 32'(RGB), 32'(BG));
        pixel(329, 240, 1'b1);
        chk("pix_left_edge", 32'(RGB), 32'(BG));
        pixel(332, 242, 1'b0);
        chk("pix_video_off", 32'(RGB), 32'h0);

        // Button priority: left+right -> red, right+middle -> blue, middle -> green
        send_packet(pkt(8'h0B, 8'h00, 8'h00));
        vblank();
        pixel(330, 240, 1'b1);
        chk("prio_lr", 32'(RGB), 32'hF00);
        send_packet(pkt(8'h0E, 8'h00, 8'h00));
        vblank();
        pixel(330, 240, 1'b1);
        chk("prio_rm", 32'(RGB), 32'h00F);
        send_packet(pkt(8'h0C, 8'h00, 8'h00));
        vblank();
        pixel(330, 240, 1'b1);
        chk("prio_m", 32'(RGB), 32'h0F0);

        // Clamping at 0: X 330-230=100, then -255 -> 0; Y 240-238=2, then -5 -> 0
        send_packet(pkt(8'h18, 8'h1A, 8'h00));
        chk("x_100", 32'(CursorX), 32'd100);
        send_packet(pkt(8'h18, 8'h01, 8'h00));
        chk("x_clamp0", 32'(CursorX), 32'd0);
        send_packet(pkt(8'h08, 8'h00, 8'hEE));
        chk("y_2", 32'(CursorY), 32'd2);
        send_packet(pkt(8'h08, 8'h00, 8'h05));
        chk("y_clamp0", 32'(CursorY), 32'd0);

        // Clamping at the far edges: X +255, Y -255 (downwards) three times
        send_packet(pkt(8'h28, 8'hFF, 8'h01));
        chk("hi_x1", 32'(CursorX), 32'd255);
        chk("hi_y1", 32'(CursorY), 32'd255);
        send_packet(pkt(8'h28, 8'hFF, 8'h01));
        chk("hi_x2", 32'(CursorX), 32'd510);
        chk("hi_y2", 32'(CursorY), 32'd479);
        send_packet(pkt(8'h28, 8'hFF, 8'h01));
        chk("hi_x3", 32'(CursorX), 32'd639);
        chk("hi_y3", 32'(CursorY), 32'd479);

        // Vblank latch in the same cycle as the ADD_X write keeps 639
        start_packet(pkt(8'h18, 8'h00, 8'h00));
        PixelTick = 1'b1;
        PixelX    = 10'd0;
        PixelY    = 10'd480;
        VideoOn   = 1'b0;
        tick();
        PixelTick = 1'b0;
        tick();
        chk("x_383", 32'(CursorX), 32'd383);
        pixel(639, 479, 1'b1);
        chk("latch_prewrite", 32'(RGB), 32'hFFF);
        pixel(383, 479, 1'b1);
        chk("latch_not_new", 32'(RGB), 32'(BG));

        // Continuous strobing: two drops per three cycles, saturating at 255
        PacketValid = 1'b1;
        MouseState  = pkt(8'h08, 8'h00, 8'h00);
        repeat (3) tick();
        chk("drop_cnt3", 32'(DropCount), 32'd3);
        repeat (447) tick();
        PacketValid = 1'b0;
        repeat (3) tick();
        chk("drop_sat", 32'(DropCount), 32'd255);
        chk("sat_x", 32'(CursorX), 32'd383);
        chk("sat_y", 32'(CursorY), 32'd479);

        // Reset in the middle of an update aborts it
        start_packet(pkt(8'h08, 8'h0A, 8'h00));
        Reset = 1'b1;
        #1;
        chk("abort_x", 32'(CursorX), 32'd320);
        tick();
        chk("abort_y", 32'(CursorY), 32'd240);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_drop", 32'(DropCount), 32'd0);
        chk("abort_rgb", 32'(RGB), 32'h0);
        chk("abort_state", 32'(DbgState), 32'(ST_IDLE));
        Reset = 1'b0;
        tick();
        start_packet(pkt(8'h08, 8'h01, 8'h00));
        chk("post_rst_busy", 32'(Busy), 32'd1);
        tick();
        chk("post_rst_x", 32'(CursorX), 32'd321);
        tick();
        chk("post_rst_y", 32'(CursorY), 32'd240);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Time bound so the run always terminates
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mouse_cursor_render.md
MOUSE_CURSOR_RENDER -- requirements
Module: mouse_cursor_render

Interface
REQ-001 Parameters: H_RES, 640, visible width in pixels; V_RES, 480, visible height in lines; CURSOR_SIZE, 8, cursor square edge in pixels; BG_COLOR, 12'h000, background RGB.
REQ-002 Clk  input  1  system clock, 50 MHz; the only clock of the block.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 PacketValid  input  1  one-cycle strobe; MouseState holds a complete mouse packet.
REQ-005 MouseState  input  32  [7:0] status byte, [15:8] X delta low bits, [23:16] Y delta low bits, [31:24] ignored.
REQ-006 PixelTick  input  1  pixel-rate enable from the VGA timing stage.
REQ-007 VideoOn  input  1  high inside the visible area.
REQ-008 PixelX, PixelY  input  10 each  current pixel coordinates.
REQ-009 RGB  output  12  {R[3:0],G[3:0],B[3:0]} pixel colour to the VGA output stage.
REQ-010 CursorX, CursorY  output  10 each  live cursor position.
REQ-011 Busy  output  1  high whenever the update FSM is not in IDLE.
REQ-012 DropCount  output  8  count of packets rejected while Busy, saturating at 255.

Function
REQ-013 Status bits: 0 Left, 1 Right, 2 Middle, 4 X sign, 5 Y sign, 6 X overflow, 7 Y overflow; deltas are 9-bit two's complement {sign, byte}.
REQ-014 FSM states IDLE, ADD_X, ADD_Y; IDLE->ADD_X on PacketValid, ADD_X->ADD_Y, ADD_Y->IDLE unconditionally.
REQ-015 On acceptance (PacketValid in IDLE, cycle N) deltas, overflow flags and buttons are captured into internal registers.
REQ-016 ADD_X (cycle N+1): CursorX <= clamp(CursorX + dX, 0, H_RES-1); new value is visible at N+2.
REQ-017 ADD_Y (cycle N+2): CursorY <= clamp(CursorY - dY, 0, V_RES-1) (positive PS/2 Y moves up); new value is visible at N+3.
REQ-018 Arithmetic is performed in 11-bit signed width; no wrap-around; results below 0 clamp to 0 and results above the limit clamp to the limit.
REQ-019 If an axis overflow flag is set, that axis is left unchanged; the other axis and buttons still update.
REQ-020 PacketValid while Busy: the packet is dropped, the FSM is unaffected, DropCount increments unless it is already 255.
REQ-021 Display latch: on PixelTick with PixelX==0 and PixelY==V_RES, DispX/DispY/DispBtn <= CursorX/CursorY/buttons; if an ADD_X/ADD_Y write occurs in the same cycle, the pre-write value is latched.
REQ-022 RGB is registered and updates only on PixelTick; latency is one Clk after the PixelTick cycle.
REQ-023 RGB is 0 when VideoOn is low.
REQ-024 Cursor hit: PixelX-DispX in [0,CURSOR_SIZE) and PixelY-DispY in [0,CURSOR_SIZE), unsigned compare; cursor pixels past the screen edge are simply not drawn.
REQ-025 Cursor colour by DispBtn priority: Left 12'hF00, else Right 12'h00F, else Middle 12'h0F0, else 12'hFFF.
REQ-026 Non-cursor visible pixel colour is BG_COLOR.

Reset
REQ-027 Reset asserted: FSM=IDLE, CursorX=DispX=H_RES/2 (320), CursorY=DispY=V_RES/2 (240), buttons=0, RGB=0, Busy=0, DropCount=0.
REQ-028 Reset mid-update aborts the update immediately with no partial axis write retained; the first PacketValid after deassertion is accepted.

Structure
REQ-029 Shared package mouse_pkg holds status bit indices, H_RES/V_RES defaults, the colour constants and the FSM state encoding.
REQ-030 One sub-module delta_clamp (signed add plus range clamp, combinational) is instantiated once per axis.

Verification
REQ-031 Reset release -> CursorX=320, CursorY=240, RGB=0, Busy=0, DropCount=0.
REQ-032 Packet status 0x08, X=0x0A, Y=0x00 at cycle N -> CursorX=330 at N+2, CursorY=240, Busy high for N+1..N+2.
REQ-033 Starting at CursorX=100: packet status 0x18, X=0x01 (-255) -> CursorX=0; packet Y=+5 from CursorY=2 -> CursorY=0.
REQ-034 Packet status 0x40, X=0x50, Y=0x03 -> CursorX unchanged, CursorY decreases by 3.
REQ-035 Second PacketValid at N+1 -> it is ignored and DropCount=1; 300 dropped packets -> DropCount=255.
REQ-036 Left held, cursor moved to (330,240): pixel (332,242) shows 12'hFFF at the old position until vblank latch, then 12'hF00; pixel (339,240) shows BG_COLOR; VideoOn=0 -> RGB=0.
